// File: rtl/goodness_accumulator.sv
// Layer goodness (sum of ReLU(mem)^2) and post-spike total over one readout sweep,
// with threshold prediction and label match for the FF learning controller.

module goodness_lane #(
  parameter int MW = 12,
  parameter int CW = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [MW-1:0]         mem,
  input  logic [CW-1:0]         s_cnt,
  output logic [2*(MW-1)-1:0]   sq,
  output logic [CW-1:0]         cnt
);
  localparam int SQW = 2 * (MW - 1);

  logic [SQW-1:0] relu;

  // Negative membranes contribute nothing; the MSB is the sign.
  assign relu = mem[MW-1] ? '0 : {{(MW-1){1'b0}}, mem[MW-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq  <= '0;
      cnt <= '0;
    end else if (en) begin
      sq  <= relu * relu;
      cnt <= s_cnt;
    end
  end
endmodule

module goodness_accumulator #(
  parameter int OUTPUT_NEURON             = 256,
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_MEM_WIDTH       = 12,
  parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
  parameter int GOODNESS_WIDTH            = 32,
  parameter int SPIKE_SUM_WIDTH           = 16
) (
  input  logic                                                  CLK,
  input  logic                                                  RST,
  input  logic                                                  START,
  input  logic                                                  LABEL_POS,
  input  logic                                                  BEAT_VALID,
  input  logic [POST_NEUR_MEM_WIDTH*POST_NEUR_PARALLEL-1:0]       MEM_BUS,
  input  logic [POST_NEUR_SPIKE_CNT_WIDTH*POST_NEUR_PARALLEL-1:0] S_CNT_BUS,
  input  logic [GOODNESS_WIDTH-1:0]                               THRESHOLD,
  output logic                                                  BUSY,
  output logic                                                  DONE,
  output logic [GOODNESS_WIDTH-1:0]                               GOODNESS,
  output logic [SPIKE_SUM_WIDTH-1:0]                              SPIKE_SUM,
  output logic                                                  PRED_POS,
  output logic                                                  MATCH,
  output logic                                                  SAT
);
  localparam int P     = POST_NEUR_PARALLEL;
  localparam int MW    = POST_NEUR_MEM_WIDTH;
  localparam int CW    = POST_NEUR_SPIKE_CNT_WIDTH;
  localparam int GW    = GOODNESS_WIDTH;
  localparam int SW    = SPIKE_SUM_WIDTH;
  localparam int BEATS = OUTPUT_NEURON / P;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SQW   = 2 * (MW - 1);
  localparam int LSW   = SQW + $clog2(P) + 1;
  localparam int CSW   = CW + $clog2(P) + 1;
  localparam int GAW   = ((GW > LSW) ? GW : LSW) + 1;
  localparam int SAW   = ((SW > CSW) ? SW : CSW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

  state_t              state, state_n;
  logic [BC_W-1:0]     bcnt;
  logic [1:0]          fcnt;
  logic                start_acc, beat, finish, s1_vld;
  logic [GW-1:0]       thr_q, acc_g;
  logic [SW-1:0]       acc_s;
  logic                label_q, sat_run;
  logic [P-1:0][SQW-1:0] sq;
  logic [P-1:0][CW-1:0]  cnt;
  logic [LSW-1:0]      gsum;
  logic [CSW-1:0]      csum;
  logic [GAW-1:0]      g_ext;
  logic [SAW-1:0]      s_ext;
  logic                g_ovf, s_ovf;

  // A START in the DONE cycle is taken directly so a back-to-back sweep loses no pulse.
  assign start_acc = START && (state == S_IDLE || state == S_DONE);
  assign beat      = (state == S_ACCUM) && BEAT_VALID;
  assign finish    = (state == S_FLUSH) && (fcnt == 2'd2);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (START) state_n = S_ACCUM;
      S_ACCUM: if (beat && bcnt == BC_W'(BEATS - 1)) state_n = S_FLUSH;
      S_FLUSH: if (finish) state_n = S_DONE;
      S_DONE:  state_n = START ? S_ACCUM : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Flush holds until stage 2 has folded the last beat into the accumulators.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt    <= '0;
      fcnt    <= '0;
      s1_vld  <= 1'b0;
      thr_q   <= '0;
      label_q <= 1'b0;
    end else begin
      s1_vld <= beat;
      fcnt   <= (state == S_FLUSH) ? fcnt + 2'd1 : 2'd0;
      if (start_acc) begin
        bcnt    <= '0;
        thr_q   <= THRESHOLD;
        label_q <= LABEL_POS;
      end else if (beat) begin
        bcnt <= bcnt + BC_W'(1);
      end
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    goodness_lane #(.MW(MW), .CW(CW)) u_lane (
      .clk   (CLK),
      .rst   (RST),
      .en    (beat),
      .mem   (MEM_BUS[i*MW +: MW]),
      .s_cnt (S_CNT_BUS[i*CW +: CW]),
      .sq    (sq[i]),
      .cnt   (cnt[i])
    );
  end

  always_comb begin
    gsum = '0;
    csum = '0;
    for (int i = 0; i < P; i++) begin
      gsum = gsum + LSW'(sq[i]);
      csum = csum + CSW'(cnt[i]);
    end
  end

  assign g_ext = GAW'(acc_g) + GAW'(gsum);
  assign s_ext = SAW'(acc_s) + SAW'(csum);
  assign g_ovf = |g_ext[GAW-1:GW];
  assign s_ovf = |s_ext[SAW-1:SW];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_g   <= '0;
      acc_s   <= '0;
      sat_run <= 1'b0;
    end else if (start_acc) begin
      acc_g   <= '0;
      acc_s   <= '0;
      sat_run <= 1'b0;
    end else if (s1_vld) begin
      acc_g   <= g_ovf ? '1 : g_ext[GW-1:0];
      acc_s   <= s_ovf ? '1 : s_ext[SW-1:0];
      sat_run <= sat_run | g_ovf | s_ovf;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GOODNESS  <= '0;
      SPIKE_SUM <= '0;
      PRED_POS  <= 1'b0;
      MATCH     <= 1'b0;
      SAT       <= 1'b0;
    end else if (finish) begin
      GOODNESS  <= acc_g;
      SPIKE_SUM <= acc_s;
      PRED_POS  <= (acc_g > thr_q);
      MATCH     <= ((acc_g > thr_q) == label_q);
      SAT       <= sat_run;
    end
  end
endmodule

// File: tb/tb_goodness_accumulator.sv
// Scoreboard bench: default-width and 28-bit-goodness instances driven in lockstep.

module tb_goodness_accumulator;
  logic        CLK = 1'b0;
  logic        RST;
  logic        START, LABEL_POS, BEAT_VALID;
  logic [47:0] MEM_BUS;
  logic [27:0] S_CNT_BUS;
  logic [31:0] THR_A;
  logic [27:0] THR_B;

  logic        BUSY_A, DONE_A, PRED_A, MATCH_A, SAT_A;
  logic [31:0] GOOD_A;
  logic [15:0] SSUM_A;
  logic        BUSY_B, DONE_B, PRED_B, MATCH_B, SAT_B;
  logic [27:0] GOOD_B;
  logic [15:0] SSUM_B;

  always #5 CLK = ~CLK;

  goodness_accumulator dut_a (
    .CLK(CLK), .RST(RST), .START(START), .LABEL_POS(LABEL_POS), .BEAT_VALID(BEAT_VALID),
    .MEM_BUS(MEM_BUS), .S_CNT_BUS(S_CNT_BUS), .THRESHOLD(THR_A),
    .BUSY(BUSY_A), .DONE(DONE_A), .GOODNESS(GOOD_A), .SPIKE_SUM(SSUM_A),
    .PRED_POS(PRED_A), .MATCH(MATCH_A), .SAT(SAT_A)
  );

  goodness_accumulator #(.GOODNESS_WIDTH(28)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .LABEL_POS(LABEL_POS), .BEAT_VALID(BEAT_VALID),
    .MEM_BUS(MEM_BUS), .S_CNT_BUS(S_CNT_BUS), .THRESHOLD(THR_B),
    .BUSY(BUSY_B), .DONE(DONE_B), .GOODNESS(GOOD_B), .SPIKE_SUM(SSUM_B),
    .PRED_POS(PRED_B), .MATCH(MATCH_B), .SAT(SAT_B)
  );

  typedef struct packed {
    logic [31:0] g;
    logic [15:0] s;
    logic        p;
    logic        m;
    logic        sat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  bit   done_seen = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every DONE strobe pops one expected result per instance.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (DONE_A) begin
      done_seen = 1;
      done_cyc  = cyc;
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done_a: DONE=1 with no sweep outstanding, expected 0");
      end else begin
        e = qa.pop_front();
        chk("a_goodness", GOOD_A, e.g);
        chk("a_spike_sum", {16'd0, SSUM_A}, {16'd0, e.s});
        chk("a_pred_pos", {31'd0, PRED_A}, {31'd0, e.p});
        chk("a_match", {31'd0, MATCH_A}, {31'd0, e.m});
        chk("a_sat", {31'd0, SAT_A}, {31'd0, e.sat});
      end
    end
    if (DONE_B) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done_b: DONE=1 with no sweep outstanding, expected 0");
      end else begin
        e = qb.pop_front();
        chk("b_goodness", {4'd0, GOOD_B}, e.g);
        chk("b_spike_sum", {16'd0, SSUM_B}, {16'd0, e.s});
        chk("b_pred_pos", {31'd0, PRED_B}, {31'd0, e.p});
        chk("b_match", {31'd0, MATCH_B}, {31'd0, e.m});
        chk("b_sat", {31'd0, SAT_B}, {31'd0, e.sat});
      end
    end
  end

  task automatic sweep(input logic [47:0] mem, input logic [27:0] sc,
                       input logic [31:0] ta, input logic [27:0] tb_, input logic lab,
                       input bit gap, input bit mid_start,
                       input exp_t ea, input exp_t eb, input int exp_lat);
    int t_cyc, b_cyc;
    @(negedge CLK);
    START = 1; LABEL_POS = lab; THR_A = ta; THR_B = tb_;
    qa.push_back(ea); qb.push_back(eb);
    done_seen = 0;
    @(negedge CLK);
    START = 0;
    t_cyc = cyc;
    chk("busy_after_start", {31'd0, BUSY_A}, 32'd1);
    for (int k = 0; k < 64; k++) begin
      MEM_BUS = mem; S_CNT_BUS = sc; BEAT_VALID = 1;
      START = (mid_start && k == 20);
      @(negedge CLK);
      START = 0;
      if (gap && k != 63) begin
        BEAT_VALID = 0; MEM_BUS = {4{12'h7FF}}; S_CNT_BUS = {4{7'd127}};
        @(negedge CLK);
      end
    end
    BEAT_VALID = 0;
    b_cyc = cyc;
    for (int w = 0; w < 12 && !done_seen; w++) begin
      @(negedge CLK); #1;
    end
    chk("done_seen", {31'd0, done_seen}, 32'd1);
    if (done_seen) begin
      chk("last_beat_to_done", done_cyc - b_cyc, 32'd3);
      if (exp_lat > 0) chk("start_to_done", done_cyc - t_cyc, exp_lat);
    end
    @(negedge CLK); #1;
    chk("done_one_cycle", {31'd0, DONE_A}, 32'd0);
    chk("busy_fall", {31'd0, BUSY_A}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; START = 0; LABEL_POS = 0; BEAT_VALID = 0;
    MEM_BUS = '0; S_CNT_BUS = '0; THR_A = '0; THR_B = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", {31'd0, BUSY_A}, 32'd0);
    chk("rst_done", {31'd0, DONE_A}, 32'd0);
    chk("rst_goodness", GOOD_A, 32'd0);
    chk("rst_spike_sum", {16'd0, SSUM_A}, 32'd0);
    RST = 0;

    // BEAT_VALID while idle must not start anything
    MEM_BUS = {4{12'h040}}; S_CNT_BUS = {4{7'd8}};
    repeat (4) begin
      BEAT_VALID = 1; @(negedge CLK);
      BEAT_VALID = 0; @(negedge CLK);
    end
    chk("idle_beat_busy", {31'd0, BUSY_A}, 32'd0);
    chk("idle_beat_goodness", GOOD_A, 32'd0);

    // Uniform: 256 * 64^2 = 1048576, 256 * 8 = 2048
    sweep({4{12'h040}}, {4{7'd8}}, 32'd1000000, 28'd1000000, 1'b1, 0, 0,
          '{32'd1048576, 16'd2048, 1'b1, 1'b1, 1'b0},
          '{32'd1048576, 16'd2048, 1'b1, 1'b1, 1'b0}, 67);

    // ReLU: two lanes of 16^2 over 64 beats = 32768, not strictly above threshold
    sweep({12'h010, 12'h800, 12'h010, 12'h800}, {4{7'd1}}, 32'd32768, 28'd32768, 1'b1, 0, 0,
          '{32'd32768, 16'd256, 1'b0, 1'b0, 1'b0},
          '{32'd32768, 16'd256, 1'b0, 1'b0, 1'b0}, 0);

    // Gapped beats with junk during gaps and a stray START mid-sweep
    sweep({4{12'h040}}, {4{7'd8}}, 32'd2000000, 28'd2000000, 1'b0, 1, 1,
          '{32'd1048576, 16'd2048, 1'b0, 1'b1, 1'b0},
          '{32'd1048576, 16'd2048, 1'b0, 1'b1, 1'b0}, 0);

    // Saturation: 256 * 2047^2 = 1072693504 fits 32 bits, clamps at 2^28-1
    sweep({4{12'h7FF}}, {4{7'd127}}, 32'd2000000000, 28'd1000, 1'b0, 0, 0,
          '{32'd1072693504, 16'd32512, 1'b0, 1'b1, 1'b0},
          '{32'd268435455, 16'd32512, 1'b1, 1'b0, 1'b1}, 67);

    // Results hold across idle cycles with beats toggling
    repeat (6) begin
      BEAT_VALID = 1; MEM_BUS = {4{12'h123}}; @(negedge CLK);
      BEAT_VALID = 0; @(negedge CLK);
    end
    #1;
    chk("hold_goodness_a", GOOD_A, 32'd1072693504);
    chk("hold_goodness_b", {4'd0, GOOD_B}, 32'd268435455);
    chk("hold_sat_b", {31'd0, SAT_B}, 32'd1);
    chk("hold_busy", {31'd0, BUSY_A}, 32'd0);

    // Reset after 30 beats: no DONE, everything back to 0
    @(negedge CLK);
    START = 1; LABEL_POS = 1; THR_A = 32'd5; THR_B = 28'd5;
    @(negedge CLK);
    START = 0; MEM_BUS = {4{12'h040}}; S_CNT_BUS = {4{7'd8}}; BEAT_VALID = 1;
    repeat (30) @(negedge CLK);
    #2 RST = 1;
    #1;
    chk("mid_rst_busy", {31'd0, BUSY_A}, 32'd0);
    chk("mid_rst_goodness_a", GOOD_A, 32'd0);
    chk("mid_rst_goodness_b", {4'd0, GOOD_B}, 32'd0);
    chk("mid_rst_spike_sum", {16'd0, SSUM_A}, 32'd0);
    chk("mid_rst_sat_b", {31'd0, SAT_B}, 32'd0);
    chk("mid_rst_pred", {31'd0, PRED_B}, 32'd0);
    BEAT_VALID = 0;
    @(negedge CLK);
    RST = 0;
    done_seen = 0;
    repeat (10) @(negedge CLK);
    #1;
    chk("no_done_after_rst", {31'd0, done_seen}, 32'd0);

    // Fresh sweep after reset reproduces Uniform
    sweep({4{12'h040}}, {4{7'd8}}, 32'd1000000, 28'd1000000, 1'b1, 0, 0,
          '{32'd1048576, 16'd2048, 1'b1, 1'b1, 1'b0},
          '{32'd1048576, 16'd2048, 1'b1, 1'b1, 1'b0}, 67);

    repeat (3) @(negedge CLK);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
